// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles the signals that connect the register-file write-port arbiter to
//   its surroundings. This includes the two writeback requesters, the register
//   file write port, the decode hazard check and the stall statistics.
//
//   master : requesters / decode / debug side. It drives valid, addr, data,
//            chk_addr_* and clr_stats.
//   slave  : arbiter side. It drives ready, rf_*, hazard_* and stall_cnt.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  // requester A (ALU writeback)
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  // requester B (load/memory writeback)
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  // register file write port
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  // decode hazard check
  logic [ADDR_W-1:0] chk_addr_a;
  logic [ADDR_W-1:0] chk_addr_b;
  logic              hazard_a;
  logic              hazard_b;
  // statistics
  logic [CNT_W-1:0]  stall_cnt;
  logic              clr_stats;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
           chk_addr_a, chk_addr_b, clr_stats,
    input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata,
           hazard_a, hazard_b, stall_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
           chk_addr_a, chk_addr_b, clr_stats,
    output a_ready, b_ready, rf_we, rf_waddr, rf_wdata,
           hazard_a, hazard_b, stall_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the single write port of the 32 x 32-bit register file between
//   ALU writeback (A) and load writeback (B).
//   - Arbitration is round-robin. It uses a 1-bit priority pointer and a
//     combinational ready.
//   - The grant is registered once before it reaches the register file.
//   - Writes to register 0 are accepted, then dropped.
//   - It reports read-after-write hazards for two decode operands.
//   - It counts stalled cycles in a saturating counter.
//
// Ports
//   clk     : clock; all state updates on the rising edge
//   reset_  : asynchronous active-low reset
//   bus     : regfile_wb_arbiter_if.slave
//             (requesters, rf write port, hazard check, stats)
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               reset_,
  regfile_wb_arbiter_if.slave bus
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t             prio_reg, prio_next;
  logic              rf_we_reg, rf_we_next;
  logic [ADDR_W-1:0] rf_waddr_reg, rf_waddr_next;
  logic [DATA_W-1:0] rf_wdata_reg, rf_wdata_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

  logic              grant_a, grant_b;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] grant_data;
  logic              stalled;

  // State registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      prio_reg      <= PRIO_A;
      rf_we_reg     <= 1'b0;
      rf_waddr_reg  <= '0;
      rf_wdata_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      prio_reg      <= prio_next;
      rf_we_reg     <= rf_we_next;
      rf_waddr_reg  <= rf_waddr_next;
      rf_wdata_reg  <= rf_wdata_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  // Arbitration, output-stage load and stall counter next state
  always_comb begin
    grant_a        = 1'b0;
    grant_b        = 1'b0;
    prio_next      = prio_reg;
    rf_we_next     = 1'b0;
    rf_waddr_next  = rf_waddr_reg;
    rf_wdata_next  = rf_wdata_reg;
    stall_cnt_next = stall_cnt_reg;

    // No grants while reset is held. Requesters keep valid and
    // re-arbitrate after release.
    if (reset_) begin
      if (bus.a_valid && (!bus.b_valid || prio_reg == PRIO_A)) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end

    grant_addr = grant_b ? bus.b_addr : bus.a_addr;
    grant_data = grant_b ? bus.b_data : bus.a_data;

    if (grant_a) prio_next = PRIO_B;
    if (grant_b) prio_next = PRIO_A;

    if (grant_a || grant_b) begin
      // Register 0 is hardwired. Its write is handshaken, then dropped here.
      rf_we_next    = (grant_addr != '0);
      rf_waddr_next = grant_addr;
      rf_wdata_next = grant_data;
    end

    stalled = (bus.a_valid && !grant_a) || (bus.b_valid && !grant_b);
    if (bus.clr_stats) begin
      stall_cnt_next = '0;
    end else if (stalled && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end
  end

  // Hazard check. The same comparator set is replicated for both decode
  // operands. It covers requests still pending and the write sitting in the
  // output stage.
  logic [ADDR_W-1:0] chk_addr [2];
  logic              hazard   [2];

  assign chk_addr[0] = bus.chk_addr_a;
  assign chk_addr[1] = bus.chk_addr_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
    assign hazard[gi] = (chk_addr[gi] != '0) &&
                        ((bus.a_valid && (bus.a_addr == chk_addr[gi])) ||
                         (bus.b_valid && (bus.b_addr == chk_addr[gi])) ||
                         (rf_we_reg   && (rf_waddr_reg == chk_addr[gi])));
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.rf_we     = rf_we_reg;
  assign bus.rf_waddr  = rf_waddr_reg;
  assign bus.rf_wdata  = rf_wdata_reg;
  assign bus.hazard_a  = hazard[0];
  assign bus.hazard_b  = hazard[1];
  assign bus.stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Directed scenario tasks and a randomized run against a reference model.
//   The model tracks round-robin turn, in-flight write, register contents and
//   a saturating integer stall count.
module tb_regfile_wb_arbiter;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk    = 1'b0;
  logic reset_ = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.chk_addr_a = '0; bus.chk_addr_b = '0; bus.clr_stats = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_ = 1'b0;
    tick(); tick();
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.chk_addr_a = 5'd3;
    bus.b_valid = 1'b1; bus.b_addr = 5'd9;
    sample();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0h exp=0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_rf_waddr got=%0h exp=0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'd0) begin failures++; $display("FAIL reset_rf_wdata got=%0h exp=0", bus.rf_wdata); end
    checks++; if (bus.stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {bus.a_ready, bus.b_ready}); end
    checks++; if (bus.hazard_a !== 1'b1) begin failures++; $display("FAIL reset_hazard_a got=%0h exp=1", bus.hazard_a); end
    $display("test_reset done");
  endtask

  task automatic test_single_write();
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'hDEADBEEF;
    sample();
    checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL single_a_ready got=%0h exp=1", bus.a_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL single_we_c1 got=%0h exp=0", bus.rf_we); end
    tick(); bus.a_valid = 1'b0;
    sample();
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
      begin failures++; $display("FAIL single_out got=%0h/%0d/%h exp=1/5/deadbeef", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    tick(); sample();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL single_we_c3 got=%0h exp=0", bus.rf_we); end
    $display("test_single_write done");
  endtask

  task automatic test_contention();
    int order [6] = '{1, 8, 2, 9, 3, 10};
    int a_list [3] = '{1, 2, 3};
    int b_list [3] = '{8, 9, 10};
    int ai = 0, bi = 0, n = 0, cyc = 0, got;
    bit ra, rb;
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'(a_list[0]); bus.a_data = $urandom;
    bus.b_valid = 1'b1; bus.b_addr = 5'(b_list[0]); bus.b_data = $urandom;
    while (n < 6 && cyc < 20) begin
      sample();
      ra = bus.a_ready; rb = bus.b_ready;
      checks++; if (ra && rb) begin failures++; $display("FAIL contention_double_grant got=11 exp=one-hot"); end
      if (ra || rb) begin
        got = ra ? int'(bus.a_addr) : int'(bus.b_addr);
        checks++; if (got != order[n]) begin failures++; $display("FAIL contention_order[%0d] got=%0d exp=%0d", n, got, order[n]); end
        $display("contention grant %0d addr=%0d", n, got);
        n++;
      end
      tick(); cyc++;
      if (ra) begin ai++; if (ai < 3) begin bus.a_addr = 5'(a_list[ai]); bus.a_data = $urandom; end else bus.a_valid = 1'b0; end
      if (rb) begin bi++; if (bi < 3) begin bus.b_addr = 5'(b_list[bi]); bus.b_data = $urandom; end else bus.b_valid = 1'b0; end
    end
    checks++; if (n != 6) begin failures++; $display("FAIL contention_timeout got=%0d grants exp=6", n); end
    sample();
    checks++; if (bus.stall_cnt !== 4'd5) begin failures++; $display("FAIL contention_stall got=%0d exp=5", bus.stall_cnt); end
    checks++; if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'd10}) begin failures++; $display("FAIL contention_last got=%0h/%0d exp=1/10", bus.rf_we, bus.rf_waddr); end
  endtask

  task automatic test_reg0();
    do_reset();
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h1234;
    sample();
    checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("FAIL reg0_b_ready got=%0h exp=1", bus.b_ready); end
    checks++; if (bus.hazard_a !== 1'b0) begin failures++; $display("FAIL reg0_hazard_a got=%0h exp=0", bus.hazard_a); end
    tick(); bus.b_valid = 1'b0;
    sample();
    checks++; if (bus.rf_we !== 1'b0) begin failures++; $display("FAIL reg0_rf_we got=%0h exp=0", bus.rf_we); end
    $display("test_reg0 done");
  endtask

  task automatic test_hazard_window();
    do_reset();
    bus.chk_addr_b = 5'd7; bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = $urandom;
    sample();
    checks++; if (bus.hazard_b !== 1'b1) begin failures++; $display("FAIL hazard_N got=%0h exp=1", bus.hazard_b); end
    tick(); bus.a_valid = 1'b0;
    sample();
    checks++; if (bus.hazard_b !== 1'b1) begin failures++; $display("FAIL hazard_N1 got=%0h exp=1", bus.hazard_b); end
    tick(); sample();
    checks++; if (bus.hazard_b !== 1'b0) begin failures++; $display("FAIL hazard_N2 got=%0h exp=0", bus.hazard_b); end
    // B to r7 blocked behind A: hazard must hold across the wait
    do_reset();
    bus.chk_addr_b = 5'd7;
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = $urandom;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = $urandom;
    sample();
    checks++; if ({bus.a_ready, bus.b_ready, bus.hazard_b} !== 3'b101) begin failures++; $display("FAIL hazard_blocked_c0 got=%b exp=101", {bus.a_ready, bus.b_ready, bus.hazard_b}); end
    tick(); bus.a_valid = 1'b0;
    sample();
    checks++; if ({bus.b_ready, bus.hazard_b} !== 2'b11) begin failures++; $display("FAIL hazard_blocked_c1 got=%b exp=11", {bus.b_ready, bus.hazard_b}); end
    tick(); bus.b_valid = 1'b0;
    sample();
    checks++; if (bus.hazard_b !== 1'b1) begin failures++; $display("FAIL hazard_blocked_c2 got=%0h exp=1", bus.hazard_b); end
    tick(); sample();
    checks++; if (bus.hazard_b !== 1'b0) begin failures++; $display("FAIL hazard_blocked_c3 got=%0h exp=0", bus.hazard_b); end
    $display("test_hazard_window done");
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] bdata;
    do_reset();
    bdata = $urandom;
    bus.a_valid = 1'b1; bus.a_addr = 5'd4;  bus.a_data = $urandom;
    bus.b_valid = 1'b1; bus.b_addr = 5'd12; bus.b_data = bdata;
    sample();
    checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL async_first_a got=%0h exp=1", bus.a_ready); end
    tick(); bus.a_valid = 1'b0;
    sample();
    checks++; if ({bus.rf_we, bus.rf_waddr} !== {1'b1, 5'd4}) begin failures++; $display("FAIL async_pre got=%0h/%0d exp=1/4", bus.rf_we, bus.rf_waddr); end
    #2 reset_ = 1'b0;
    #1;
    checks++; if ({bus.rf_we, bus.b_ready} !== 2'b00) begin failures++; $display("FAIL async_cancel got=%b exp=00", {bus.rf_we, bus.b_ready}); end
    tick(); reset_ = 1'b1;
    sample();
    checks++; if ({bus.a_ready, bus.b_ready} !== 2'b01) begin failures++; $display("FAIL async_regrant got=%b exp=01", {bus.a_ready, bus.b_ready}); end
    tick(); bus.b_valid = 1'b0;
    sample();
    checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd12, bdata})
      begin failures++; $display("FAIL async_write got=%0h/%0d/%h exp=1/12/%h", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bdata); end
    $display("test_async_reset done");
  endtask

  task automatic test_saturation();
    do_reset();
    bus.a_valid = 1'b1; bus.a_addr = 5'd2; bus.a_data = $urandom;
    bus.b_valid = 1'b1; bus.b_addr = 5'd6; bus.b_data = $urandom;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14 || i == 19) begin
        sample();
        checks++; if (bus.stall_cnt !== 4'(CNT_MAX)) begin failures++; $display("FAIL sat_cycle%0d got=%0d exp=%0d", i + 1, bus.stall_cnt, CNT_MAX); end
      end
    end
    bus.clr_stats = 1'b1;
    tick(); bus.clr_stats = 1'b0;
    sample();
    checks++; if (bus.stall_cnt !== 4'd0) begin failures++; $display("FAIL sat_clear got=%0d exp=0", bus.stall_cnt); end
    tick(); sample();
    checks++; if (bus.stall_cnt !== 4'd1) begin failures++; $display("FAIL sat_after_clear got=%0d exp=1", bus.stall_cnt); end
    $display("test_saturation done stall=%0d", bus.stall_cnt);
  endtask

  task automatic test_random();
    int                m_turn = 0;   // 0: A favoured on contention, 1: B
    bit                m_we = 1'b0;
    int                m_waddr = 0;
    logic [DATA_W-1:0] m_wdata = '0;
    int                m_cnt = 0;
    logic [DATA_W-1:0] m_rf [32];
    logic [DATA_W-1:0] d_rf [32];
    bit ea, eb, eha, ehb, ra, rb;
    int ca, cb, gaddr;
    logic [DATA_W-1:0] gdata;
    do_reset();
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; d_rf[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!bus.a_valid && $urandom_range(0, 99) < 60) begin bus.a_valid = 1'b1; bus.a_addr = 5'($urandom_range(0, 7)); bus.a_data = $urandom; end
      if (!bus.b_valid && $urandom_range(0, 99) < 60) begin bus.b_valid = 1'b1; bus.b_addr = 5'($urandom_range(0, 7)); bus.b_data = $urandom; end
      bus.chk_addr_a = 5'($urandom_range(0, 7));
      bus.chk_addr_b = 5'($urandom_range(0, 7));
      bus.clr_stats  = ($urandom_range(0, 31) == 0);
      sample();
      ea = bus.a_valid && (!bus.b_valid || m_turn == 0);
      eb = bus.b_valid && !ea;
      ca = int'(bus.chk_addr_a); cb = int'(bus.chk_addr_b);
      eha = ca != 0 && ((bus.a_valid && int'(bus.a_addr) == ca) || (bus.b_valid && int'(bus.b_addr) == ca) || (m_we && m_waddr == ca));
      ehb = cb != 0 && ((bus.a_valid && int'(bus.a_addr) == cb) || (bus.b_valid && int'(bus.b_addr) == cb) || (m_we && m_waddr == cb));
      ra = bus.a_ready; rb = bus.b_ready;
      checks++; if ({ra, rb} !== {ea, eb}) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, {ra, rb}, {ea, eb}); end
      checks++; if ({bus.hazard_a, bus.hazard_b} !== {eha, ehb}) begin failures++; $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", cyc, {bus.hazard_a, bus.hazard_b}, {eha, ehb}); end
      checks++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {m_we, 5'(m_waddr), m_wdata})
        begin failures++; $display("FAIL rnd_out cyc=%0d got=%0h/%0d/%h exp=%0h/%0d/%h", cyc, bus.rf_we, bus.rf_waddr, bus.rf_wdata, m_we, m_waddr, m_wdata); end
      checks++; if (int'(bus.stall_cnt) != m_cnt) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, bus.stall_cnt, m_cnt); end
      if (bus.rf_we) d_rf[bus.rf_waddr] = bus.rf_wdata;
      // advance the model by one clock
      if (bus.clr_stats) m_cnt = 0;
      else if (((bus.a_valid && !ea) || (bus.b_valid && !eb)) && m_cnt < CNT_MAX) m_cnt++;
      if (ea || eb) begin
        gaddr = ea ? int'(bus.a_addr) : int'(bus.b_addr);
        gdata = ea ? bus.a_data : bus.b_data;
        m_we = (gaddr != 0); m_waddr = gaddr; m_wdata = gdata;
        if (gaddr != 0) m_rf[gaddr] = gdata;
        m_turn = ea ? 1 : 0;
      end else begin
        m_we = 1'b0;
      end
      tick();
      if (ra) bus.a_valid = 1'b0;
      if (rb) bus.b_valid = 1'b0;
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0; bus.clr_stats = 1'b0;
    sample();
    if (bus.rf_we) d_rf[bus.rf_waddr] = bus.rf_wdata;
    for (int r = 0; r < 32; r++) begin
      checks++; if (d_rf[r] !== m_rf[r]) begin failures++; $display("FAIL rnd_regfile r%0d got=%h exp=%h", r, d_rf[r], m_rf[r]); end
    end
    $display("test_random done");
  endtask

  initial begin
    idle_inputs();
    #2 reset_ = 1'b0;
    test_reset();
    test_single_write();
    test_contention();
    test_reg0();
    test_hazard_window();
    test_async_reset();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
